// File: rtl/tick_monitor.sv
// tick_monitor
//   Consumer-side checker for the interval timer's one-cycle tick strobe.
//   It detects rising edges on i_tick, counts clock cycles between
//   consecutive edges and reports each interval as a registered period.
//   Each period is classified against the window
//   [EXPECTED-TOL, EXPECTED+TOL] as early, in-window or late.
//
// Ports
//   clock          : system clock, all logic on the rising edge
//   rst            : synchronous active-high reset, dominates all inputs
//   i_tick         : tick strobe; only its rising edge counts
//   o_period       : cycles between the last two tick edges (held)
//   o_period_valid : one-cycle pulse when o_period updates
//   o_early_err    : one-cycle pulse, measured period < EXPECTED-TOL
//   o_late_err     : one-cycle pulse, window closed with no tick seen
//   o_locked       : high while the latest classification was in-window
//   o_miss_count   : number of late_err events, saturating at 255
//   o_state        : debug view of the FSM (0 IDLE, 1 MEASURE, 2 LATE)
module tick_monitor #(
  parameter int WIDTH    = 32,
  parameter int EXPECTED = 50000000,
  parameter int TOL      = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_early_err,
  output logic             o_late_err,
  output logic             o_locked,
  output logic [7:0]       o_miss_count,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LATE    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] WIN_LO  = WIDTH'(EXPECTED - TOL);
  localparam logic [WIDTH-1:0] WIN_HI  = WIDTH'(EXPECTED + TOL);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t           r_state;
  logic             r_tick_d;
  logic [WIDTH-1:0] r_cnt;
  logic             w_edge;

  // Resetting r_tick_d to 0 makes a tick held high across reset release
  // count as an edge on the first sampled cycle.
  assign w_edge = i_tick & ~r_tick_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_tick_d       <= 1'b0;
      r_cnt          <= '0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_early_err    <= 1'b0;
      o_late_err     <= 1'b0;
      o_locked       <= 1'b0;
      o_miss_count   <= '0;
    end else begin
      r_tick_d       <= i_tick;
      o_period_valid <= 1'b0;
      o_early_err    <= 1'b0;
      o_late_err     <= 1'b0;

      // At an edge r_cnt holds the full interval since the previous edge,
      // because it was loaded with 1 on the cycle of that edge.
      if (w_edge) begin
        r_cnt <= WIDTH'(1);
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + WIDTH'(1);
      end

      case (r_state)
        S_IDLE: begin
          // First edge only opens the measurement; nothing to report yet.
          if (w_edge) begin
            r_state <= S_MEASURE;
          end
        end

        S_MEASURE: begin
          if (w_edge) begin
            o_period       <= r_cnt;
            o_period_valid <= 1'b1;
            if (r_cnt < WIN_LO) begin
              o_early_err <= 1'b1;
              o_locked    <= 1'b0;
            end else begin
              o_locked <= 1'b1;
            end
          end else if (r_cnt == WIN_HI) begin
            // Window closed without a tick: report once, then wait in LATE.
            o_late_err <= 1'b1;
            o_locked   <= 1'b0;
            if (o_miss_count != 8'hFF) begin
              o_miss_count <= o_miss_count + 8'd1;
            end
            r_state <= S_LATE;
          end
        end

        S_LATE: begin
          // The long interval is still reported, but already counted as a
          // miss, so no further error pulse and locked stays low.
          if (w_edge) begin
            o_period       <= r_cnt;
            o_period_valid <= 1'b1;
            r_state        <= S_MEASURE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_tick_monitor.sv
module tb_tick_monitor;

  localparam int WIDTH    = 32;
  localparam int EXPECTED = 5;
  localparam int TOL      = 1;

  // clock / reset
  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic i_tick = 1'b0;

  always #5 clock = ~clock;

  logic [WIDTH-1:0] o_period;
  logic             o_period_valid;
  logic             o_early_err;
  logic             o_late_err;
  logic             o_locked;
  logic [7:0]       o_miss_count;
  logic [1:0]       o_state;

  tick_monitor #(
    .WIDTH   (WIDTH),
    .EXPECTED(EXPECTED),
    .TOL     (TOL)
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .i_tick        (i_tick),
    .o_period      (o_period),
    .o_period_valid(o_period_valid),
    .o_early_err   (o_early_err),
    .o_late_err    (o_late_err),
    .o_locked      (o_locked),
    .o_miss_count  (o_miss_count),
    .o_state       (o_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works from absolute edge timestamps, not a counter.
  int          cyc = 0;
  int          last_edge_cyc = 0;
  bit          have_prev = 0;
  bit          missed = 0;
  logic        prev_tick = 1'b0;
  logic [WIDTH-1:0] m_period = '0;
  logic        m_valid = 0, m_early = 0, m_late = 0, m_locked = 0;
  int          m_miss = 0;
  logic [1:0]  m_state = 2'd0;

  // Model update on each rising edge, compare once the DUT has settled.
  always @(posedge clock) begin
    int interval;
    logic e;
    if (rst) begin
      have_prev = 0; missed = 0; prev_tick = 1'b0;
      m_period = '0; m_valid = 0; m_early = 0; m_late = 0;
      m_locked = 0; m_miss = 0;
    end else begin
      e = i_tick & ~prev_tick;
      prev_tick = i_tick;
      m_valid = 0; m_early = 0; m_late = 0;
      interval = cyc - last_edge_cyc;
      if (e) begin
        if (have_prev) begin
          m_period = WIDTH'(interval);
          m_valid  = 1;
          if (!missed) begin
            if (interval < EXPECTED - TOL) begin
              m_early = 1; m_locked = 0;
            end else begin
              m_locked = 1;
            end
          end
        end
        missed = 0;
        have_prev = 1;
        last_edge_cyc = cyc;
      end else if (have_prev && !missed && interval == EXPECTED + TOL) begin
        m_late = 1; m_locked = 0; missed = 1;
        m_miss = (m_miss < 255) ? m_miss + 1 : 255;
      end
    end
    m_state = !have_prev ? 2'd0 : (missed ? 2'd2 : 2'd1);
    cyc++;
    #1;
    check("period",       o_period,       m_period);
    check("period_valid", o_period_valid, m_valid);
    check("early_err",    o_early_err,    m_early);
    check("late_err",     o_late_err,     m_late);
    check("locked",       o_locked,       m_locked);
    check("miss_count",   o_miss_count,   m_miss);
    check("state",        o_state,        m_state);
  end

  // driver tasks: inputs change on the falling edge
  task automatic drive(input logic t, input logic r);
    @(negedge clock);
    i_tick = t;
    rst    = r;
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic pulse_gap(input int gap);
    drive(1'b1, 1'b0);
    zeros(gap - 1);
  endtask

  task automatic edge_now();
    drive(1'b1, 1'b0);
    settle();
  endtask

  initial begin
    // reset
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    settle();
    check("lit_reset_period", o_period, 0);
    check("lit_reset_locked", o_locked, 0);
    check("lit_reset_miss",   o_miss_count, 0);
    check("lit_reset_state",  o_state, 0);

    // 1: regular 5-cycle ticks
    drive(1'b1, 1'b0);
    settle();
    check("lit_first_edge_no_valid", o_period_valid, 0);
    check("lit_first_edge_state",    o_state, 1);
    zeros(4);
    pulse_gap(5);
    pulse_gap(5);
    edge_now();
    check("lit_s1_period", o_period, 5);
    check("lit_s1_valid",  o_period_valid, 1);
    check("lit_s1_locked", o_locked, 1);
    check("lit_s1_miss",   o_miss_count, 0);

    // 2: intervals 4, 6, 3
    zeros(3);
    pulse_gap(6);
    pulse_gap(3);
    edge_now();
    check("lit_s2_period", o_period, 3);
    check("lit_s2_early",  o_early_err, 1);
    check("lit_s2_locked", o_locked, 0);

    // 3: silence after a tick
    zeros(5);
    drive(1'b0, 1'b0);
    settle();
    check("lit_s3_late",  o_late_err, 1);
    check("lit_s3_miss",  o_miss_count, 1);
    check("lit_s3_state", o_state, 2);
    zeros(2);
    edge_now();
    check("lit_s3_period", o_period, 9);
    check("lit_s3_valid",  o_period_valid, 1);
    check("lit_s3_early",  o_early_err, 0);
    check("lit_s3_locked", o_locked, 0);
    zeros(4);
    edge_now();
    check("lit_s3_relock", o_locked, 1);

    // 4: tick held high 4 cycles every 5
    zeros(4);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
    end
    edge_now();
    check("lit_s4_period", o_period, 5);
    check("lit_s4_locked", o_locked, 1);
    check("lit_s4_early",  o_early_err, 0);

    // 5: reset in LATE coincident with a rising tick
    drive(1'b0, 1'b0);
    zeros(7);
    drive(1'b1, 1'b1);
    settle();
    check("lit_s5_state",  o_state, 0);
    check("lit_s5_period", o_period, 0);
    check("lit_s5_miss",   o_miss_count, 0);
    zeros(2);
    edge_now();
    check("lit_s5_no_valid", o_period_valid, 0);

    // 6: 256+ consecutive missed intervals of 7
    zeros(6);
    for (int i = 0; i < 256; i++) pulse_gap(7);
    edge_now();
    check("lit_s6_period", o_period, 7);
    check("lit_s6_miss",   o_miss_count, 255);

    // random intervals, pulse widths and occasional resets
    for (int i = 0; i < 300; i++) begin
      int gap;
      int hi;
      gap = $urandom_range(2, 9);
      hi  = $urandom_range(1, gap - 1);
      for (int j = 0; j < gap; j++) begin
        drive(j < hi, ($urandom_range(0, 199) == 0));
      end
    end
    drive(1'b0, 1'b0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
